// File: rtl/uart_pkg.sv
// Shared types and helpers for the response UART transmitter.
package uart_pkg;

    // Response sequencing states. The top parks in START while the serializer
    // runs the frame; DATA and STOP name the serializer's phases.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4,
        NEXT  = 3'd5,
        DONE  = 3'd6
    } uart_resp_state_t;

    // Bit serializer states
    typedef enum logic [1:0] {
        BIT_IDLE  = 2'd0,
        BIT_START = 2'd1,
        BIT_DATA  = 2'd2,
        BIT_STOP  = 2'd3
    } uart_bit_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Clock cycles per UART bit, truncated
    function automatic int bit_cycles(input int clk, input int baud);
        return clk / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 bit serializer: one start bit, eight data bits LSB first, one stop bit.
// Accepts a byte only while idle; byte_done marks the last cycle of the stop bit.
module uart_tx_byte #(
    parameter int BIT_CYCLES = 234
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       byte_done,
    output logic       tx
);
    import uart_pkg::*;

    localparam int TIMER_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BIT_CYCLES - 1);

    uart_bit_state_t    state_reg, state_next;
    logic [TIMER_W-1:0] timer_reg;
    logic [2:0]         bit_idx_reg;
    logic [7:0]         shift_reg;
    logic               bit_end;

    assign bit_end = (timer_reg == TIMER_LAST);

    // State register; async reset drops any frame in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= BIT_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: each phase ends when the bit timer reaches its last count
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BIT_IDLE:  if (byte_valid) state_next = BIT_START;
            BIT_START: if (bit_end) state_next = BIT_DATA;
            BIT_DATA:  if (bit_end && (bit_idx_reg == 3'd7)) state_next = BIT_STOP;
            BIT_STOP:  if (bit_end) state_next = BIT_IDLE;
            default:   state_next = BIT_IDLE;
        endcase
    end

    // Bit timer, bit index and shift register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer_reg   <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            if (state_reg == BIT_IDLE || bit_end) begin
                timer_reg <= '0;
            end else begin
                timer_reg <= timer_reg + TIMER_W'(1);
            end
            if (state_reg == BIT_IDLE && byte_valid) begin
                shift_reg <= byte_in;
            end else if (state_reg == BIT_DATA && bit_end) begin
                shift_reg   <= {1'b0, shift_reg[7:1]};
                bit_idx_reg <= bit_idx_reg + 3'd1;
            end
        end
    end

    // Line level and handshake outputs decoded from state
    always_comb begin
        byte_ready = (state_reg == BIT_IDLE);
        byte_done  = (state_reg == BIT_STOP) && bit_end;
        tx         = UART_IDLE_LEVEL;
        case (state_reg)
            BIT_START: tx = 1'b0;
            BIT_DATA:  tx = shift_reg[0];
            default:   tx = UART_IDLE_LEVEL;
        endcase
    end

endmodule

// File: rtl/uart_response_tx.sv
// Latches a whole response string on accept and sends it byte by byte over
// the host UART. The serializer owns the bit timing; this level owns the
// buffer, the byte index and the per-response sequencing.
module uart_response_tx #(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int BAUD_RATE       = 115200,
    parameter int MAX_LEN         = 21
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] resp_data [0:MAX_LEN-1],
    input  logic [7:0] resp_len,
    input  logic       resp_valid,
    output logic       resp_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       resp_dropped,
    output logic       uart_tx
);
    import uart_pkg::*;

    localparam int BIT_CYCLES = bit_cycles(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int IDX_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    uart_resp_state_t state_reg, state_next;
    logic [7:0] resp_buf_reg [0:MAX_LEN-1];
    logic [7:0] len_reg;
    logic [7:0] idx_reg;
    logic       accept;
    logic       more_bytes;
    logic       byte_valid;
    logic       byte_ready;
    logic       byte_done;
    logic [7:0] byte_in;

    assign accept     = (state_reg == IDLE) && resp_valid;
    assign more_bytes = ({1'b0, idx_reg} + 9'd1) < {1'b0, len_reg};
    assign byte_in    = resp_buf_reg[idx_reg[IDX_W-1:0]];

    // Snapshot every byte on accept so the producer can reuse its buffer at once
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_buf
        always_ff @(posedge clock) begin
            if (accept) begin
                resp_buf_reg[gi] <= resp_data[gi];
            end
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: walk the buffer one byte per serializer frame
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (resp_valid) state_next = LOAD;
            LOAD: begin
                if (len_reg == 8'd0) begin
                    state_next = DONE;
                end else if (byte_ready) begin
                    state_next = START;
                end
            end
            START: if (byte_done) state_next = NEXT;
            NEXT:  state_next = more_bytes ? LOAD : DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Clamped length and byte index; the index only advances while bytes remain
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            len_reg <= '0;
            idx_reg <= '0;
        end else if (accept) begin
            len_reg <= (resp_len > MAX_LEN_B) ? MAX_LEN_B : resp_len;
            idx_reg <= '0;
        end else if (state_reg == NEXT && more_bytes) begin
            idx_reg <= idx_reg + 8'd1;
        end
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        resp_ready   = (state_reg == IDLE);
        busy         = (state_reg != IDLE);
        tx_done      = (state_reg == DONE);
        resp_dropped = resp_valid && (state_reg != IDLE);
        byte_valid   = (state_reg == LOAD) && (len_reg != 8'd0);
    end

    uart_tx_byte #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_tx_byte (
        .clock      (clock),
        .reset_n    (reset_n),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_done  (byte_done),
        .tx         (uart_tx)
    );

endmodule

// File: tb/tb_uart_response_tx.sv
// Directed + randomized bench for uart_response_tx at 16 cycles per bit.
// A line monitor decodes 8N1 frames independently; expected bytes are the
// first min(len, 21) bytes of each request.
module tb_uart_response_tx;

    localparam int MAXL = 21;
    localparam int BITC = 16;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] req_data [0:MAXL-1];
    logic [7:0] resp_len;
    logic       resp_valid;
    logic       resp_ready, busy, tx_done, resp_dropped, uart_tx;

    int errors = 0;
    int checks = 0;

    uart_response_tx #(
        .CLOCK_FREQUENCY (16),
        .BAUD_RATE       (1),
        .MAX_LEN         (MAXL)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .resp_data    (req_data),
        .resp_len     (resp_len),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .busy         (busy),
        .tx_done      (tx_done),
        .resp_dropped (resp_dropped),
        .uart_tx      (uart_tx)
    );

    always #5 clock = ~clock;

    // ---------------- line monitor ----------------
    logic [7:0] rx_q [$];
    int  low_cycles = 0;
    int  done_count = 0;
    int  stop_errs  = 0;
    bit  mon_active = 1'b0;
    int  mon_cnt    = 0;
    logic [7:0] mon_byte = 8'h00;

    always @(negedge clock) begin
        if (uart_tx !== 1'b1) low_cycles <= low_cycles + 1;
        if (tx_done === 1'b1) done_count <= done_count + 1;
        if (reset_n !== 1'b1) begin
            mon_active <= 1'b0;
        end else if (!mon_active) begin
            if (uart_tx === 1'b0) begin
                mon_active <= 1'b1;
                mon_cnt    <= 0;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if ((mon_cnt + 1) % BITC == BITC / 2) begin
                if ((mon_cnt + 1) / BITC >= 1 && (mon_cnt + 1) / BITC <= 8) begin
                    mon_byte <= {uart_tx, mon_byte[7:1]};
                end else if ((mon_cnt + 1) / BITC == 9) begin
                    rx_q.push_back(mon_byte);
                    if (uart_tx !== 1'b1) stop_errs <= stop_errs + 1;
                    mon_active <= 1'b0;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic line_log [0:3499];

    // Issue one request from a negedge; follow it until tx_done or a bound.
    // poke_k: raise resp_valid for one cycle at that cycle offset.
    // rst_k:  assert reset at that cycle offset and stop following.
    task automatic run_req(input string tag, input int len, input int poke_k, input int rst_k,
                           output int done_k, output int busy_low);
        int budget;
        budget   = MAXL * (10 * BITC + 2) + 20;
        done_k   = -1;
        busy_low = 0;
        check({tag, "_ready_before"}, resp_ready, 1);
        resp_len   = 8'(len);
        resp_valid = 1'b1;
        @(posedge clock);
        #1 resp_valid = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clock);
            resp_valid  = 1'b0;
            line_log[k] = uart_tx;
            if (tx_done === 1'b1) begin
                done_k = k;
                break;
            end
            if (busy !== 1'b1) busy_low++;
            if (k == poke_k) begin
                resp_valid = 1'b1;
                #1;
                check({tag, "_dropped"}, resp_dropped, 1);
                check({tag, "_ready_busy"}, resp_ready, 0);
            end
            if (k == rst_k) begin
                check({tag, "_line_low_before_rst"}, uart_tx, 0);
                reset_n = 1'b0;
                #1;
                check({tag, "_rst_uart_tx"}, uart_tx, 1);
                check({tag, "_rst_ready"}, resp_ready, 1);
                check({tag, "_rst_busy"}, busy, 0);
                break;
            end
        end
    endtask

    task automatic compare_rx(input string tag, input int len);
        int n;
        n = (len < MAXL) ? len : MAXL;
        check({tag, "_rx_count"}, rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), rx_q[i], req_data[i]);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < MAXL; i++) req_data[i] = 8'($urandom);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int done_k, busy_low, lows, dones, wave_bad, len;
        logic [9:0] frame;
        string s;

        reset_n    = 1'b0;
        resp_valid = 1'b0;
        resp_len   = 8'd0;
        for (int i = 0; i < MAXL; i++) req_data[i] = 8'h00;

        // 1. reset state and idle line
        repeat (3) @(negedge clock);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_ready", resp_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_dropped", resp_dropped, 0);
        reset_n = 1'b1;
        lows = low_cycles;
        repeat (50) @(negedge clock);
        check("idle_line_low_cycles", low_cycles - lows, 0);
        $display("txn reset/idle: done");

        // 2. single byte 0xA5, exact waveform
        req_data[0] = 8'hA5;
        rx_q.delete();
        dones = done_count;
        run_req("t2", 1, 0, 0, done_k, busy_low);
        frame = {1'b1, 8'hA5, 1'b0};
        wave_bad = 0;
        if (line_log[1] !== 1'b1) wave_bad++;
        for (int k = 2; k < 2 + 10 * BITC; k++) begin
            if (line_log[k] !== frame[(k - 2) / BITC]) wave_bad++;
        end
        check("t2_wave_mismatch_cycles", wave_bad, 0);
        check("t2_done_in_161_163", (done_k >= 161 && done_k <= 163), 1);
        check("t2_busy_low", busy_low, 0);
        repeat (4) @(negedge clock);
        check("t2_done_pulses", done_count - dones, 1);
        compare_rx("t2", 1);
        $display("txn t2 len=1 done_k=%0d rx=%0d", done_k, rx_q.size());

        // 3. full 21-byte response string
        s = "pb_i__read,AAABACAD\r\n";
        for (int i = 0; i < MAXL; i++) req_data[i] = s[i];
        rx_q.delete();
        dones = done_count;
        run_req("t3", 21, 0, 0, done_k, busy_low);
        check("t3_busy_low", busy_low, 0);
        repeat (4) @(negedge clock);
        check("t3_done_pulses", done_count - dones, 1);
        compare_rx("t3", 21);
        $display("txn t3 len=21 done_k=%0d rx=%0d", done_k, rx_q.size());

        // 4a. zero length: no line activity, tx_done two cycles after accept
        rx_q.delete();
        lows = low_cycles;
        run_req("t4a", 0, 0, 0, done_k, busy_low);
        check("t4a_done_k", done_k, 2);
        repeat (4) @(negedge clock);
        check("t4a_line_low_cycles", low_cycles - lows, 0);
        compare_rx("t4a", 0);
        $display("txn t4a len=0 done_k=%0d", done_k);

        // 4b. oversize length clamps to 21
        fill_random();
        rx_q.delete();
        run_req("t4b", 40, 0, 0, done_k, busy_low);
        repeat (4) @(negedge clock);
        compare_rx("t4b", 40);
        $display("txn t4b len=40 rx=%0d", rx_q.size());

        // random requests against the model
        for (int r = 0; r < 4; r++) begin
            fill_random();
            len = $urandom_range(0, 26);
            rx_q.delete();
            dones = done_count;
            run_req($sformatf("rnd%0d", r), len, 0, 0, done_k, busy_low);
            repeat (4) @(negedge clock);
            check($sformatf("rnd%0d_done_pulses", r), done_count - dones, 1);
            compare_rx($sformatf("rnd%0d", r), len);
            $display("txn rnd%0d len=%0d rx=%0d", r, len, rx_q.size());
        end

        // 5. request while busy is dropped; frame unaffected
        fill_random();
        rx_q.delete();
        run_req("t5", 3, 40, 0, done_k, busy_low);
        repeat (4) @(negedge clock);
        compare_rx("t5", 3);
        $display("txn t5 len=3 with drop rx=%0d", rx_q.size());

        // 6. async reset in byte 1 data bit 1, then recover
        fill_random();
        req_data[1] = 8'h00;
        rx_q.delete();
        run_req("t6", 2, 0, 200, done_k, busy_low);
        repeat (3) @(negedge clock);
        check("t6_line_in_reset", uart_tx, 1);
        reset_n = 1'b1;
        @(negedge clock);
        check("t6_ready_after", resp_ready, 1);
        rx_q.delete();
        fill_random();
        run_req("t6b", 1, 0, 0, done_k, busy_low);
        repeat (4) @(negedge clock);
        compare_rx("t6b", 1);
        check("stop_bit_errors", stop_errs, 0);
        $display("txn t6 reset mid-frame, recovery rx=%0d", rx_q.size());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
